// File: rtl/pipe_datapath_p_if.sv
// Instruction-fetch and data-memory bus between pipe_datapath_p (master)
// and the surrounding memory system (slave).
interface pipe_datapath_p_if #(
    parameter int DW = 24,
    parameter int AW = 16
);
    logic [AW-1:0] pc;
    logic [23:0]   inst;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWData;
    logic          memWE;
    logic [DW-1:0] memRData;

    modport master (output pc, memAddr, memWData, memWE, input inst, memRData);
    modport slave  (input pc, memAddr, memWData, memWE, output inst, memRData);
endinterface

// File: rtl/pipe_datapath_p.sv
// Three-stage (decode / execute+memory / writeback) datapath with W->E
// forwarding, register-file write-through, branch squash and global stall.
module pipe_datapath_p #(
    parameter int DW   = 24,
    parameter int AW   = 16,
    parameter int NREG = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       regWrite,
    input  logic       aluSrc,
    input  logic       immSrc,
    input  logic       memToReg,
    input  logic       memWrite,
    input  logic       ra2Src,
    input  logic       PCSrc,
    input  logic [1:0] aluControl,
    pipe_datapath_p_if.master bus,
    output logic       cero,
    output logic       negativo,
    output logic       acarreo,
    output logic       desbordamiento
);
    localparam int RW = $clog2(NREG);
    localparam logic [RW-1:0] PC_IDX = RW'(NREG - 1);

    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];

    logic [DW-1:0] op_a_e_q, op_a_e_d, op_b_e_q, op_b_e_d, imm_e_q, imm_e_d;
    logic [RW-1:0] ra1_e_q, ra1_e_d, ra2_e_q, ra2_e_d, wa_e_q, wa_e_d;
    logic          reg_write_e_q, reg_write_e_d, alu_src_e_q, alu_src_e_d;
    logic          mem_to_reg_e_q, mem_to_reg_e_d, mem_write_e_q, mem_write_e_d;
    logic          pc_src_e_q, pc_src_e_d, valid_e_q, valid_e_d;
    logic [1:0]    alu_ctl_e_q, alu_ctl_e_d;

    logic [DW-1:0] result_w_q, result_w_d;
    logic [RW-1:0] wa_w_q, wa_w_d;
    logic          reg_write_w_q, reg_write_w_d, valid_w_q, valid_w_d;
    logic [3:0]    flags_q, flags_d;

    logic [RW-1:0] ra1_s, ra2_s, wa_s;
    logic [11:0]   imm12_s;
    logic [DW-1:0] imm_s, rd1_s, rd2_s;
    logic [AW-1:0] pc_inc_s;
    logic          w_fwd_s, wr_en_s, branch_s;
    logic [DW-1:0] fwd_a_s, fwd_b_s, src_b_s, alu_res_s, result_e_s;
    logic [DW:0]   sum_s, diff_s;
    logic          alu_c_s, alu_v_s;
    logic          unused_s;

    assign unused_s = ^{bus.inst[23:20]};

    // Decode: register indices and immediate of the instruction in D.
    always_comb begin
        ra1_s   = bus.inst[12 +: RW];
        wa_s    = bus.inst[16 +: RW];
        ra2_s   = ra2Src ? bus.inst[16 +: RW] : bus.inst[8 +: RW];
        imm12_s = bus.inst[11:0];
        if (immSrc) begin
            imm_s = DW'($signed(imm12_s));
        end else begin
            imm_s = DW'(imm12_s);
        end
    end

    // Register-file read; the top index aliases pc+1, a pending W write is passed through.
    always_comb begin
        w_fwd_s  = reg_write_w_q & valid_w_q & (wa_w_q != PC_IDX);
        wr_en_s  = w_fwd_s & ~stall;
        pc_inc_s = pc_q + AW'(1);
        if (ra1_s == PC_IDX) begin
            rd1_s = DW'(pc_inc_s);
        end else if (w_fwd_s && (wa_w_q == ra1_s)) begin
            rd1_s = result_w_q;
        end else begin
            rd1_s = rf_q[ra1_s];
        end
        if (ra2_s == PC_IDX) begin
            rd2_s = DW'(pc_inc_s);
        end else if (w_fwd_s && (wa_w_q == ra2_s)) begin
            rd2_s = result_w_q;
        end else begin
            rd2_s = rf_q[ra2_s];
        end
    end

    // Execute: operand forwarding from W, ALU and flag generation.
    always_comb begin
        fwd_a_s = (w_fwd_s && (wa_w_q == ra1_e_q)) ? result_w_q : op_a_e_q;
        fwd_b_s = (w_fwd_s && (wa_w_q == ra2_e_q)) ? result_w_q : op_b_e_q;
        src_b_s = alu_src_e_q ? imm_e_q : fwd_b_s;
        sum_s   = {1'b0, fwd_a_s} + {1'b0, src_b_s};
        diff_s  = {1'b0, fwd_a_s} + {1'b0, ~src_b_s} + (DW+1)'(1);
        case (alu_ctl_e_q)
            2'b00: begin
                alu_res_s = sum_s[DW-1:0];
                alu_c_s   = sum_s[DW];
                alu_v_s   = (fwd_a_s[DW-1] == src_b_s[DW-1]) & (alu_res_s[DW-1] != fwd_a_s[DW-1]);
            end
            2'b01: begin
                alu_res_s = diff_s[DW-1:0];
                alu_c_s   = diff_s[DW];
                alu_v_s   = (fwd_a_s[DW-1] != src_b_s[DW-1]) & (alu_res_s[DW-1] != fwd_a_s[DW-1]);
            end
            2'b10: begin
                alu_res_s = fwd_a_s & src_b_s;
                alu_c_s   = 1'b0;
                alu_v_s   = 1'b0;
            end
            default: begin
                alu_res_s = fwd_a_s | src_b_s;
                alu_c_s   = 1'b0;
                alu_v_s   = 1'b0;
            end
        endcase
        result_e_s = mem_to_reg_e_q ? bus.memRData : alu_res_s;
        branch_s   = pc_src_e_q & valid_e_q & ~stall;
    end

    // Next state of every register; stall holds everything.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            rf_d[i] = (wr_en_s && (wa_w_q == RW'(i))) ? result_w_q : rf_q[i];
        end
        pc_d           = pc_q;
        op_a_e_d       = op_a_e_q;
        op_b_e_d       = op_b_e_q;
        imm_e_d        = imm_e_q;
        ra1_e_d        = ra1_e_q;
        ra2_e_d        = ra2_e_q;
        wa_e_d         = wa_e_q;
        reg_write_e_d  = reg_write_e_q;
        alu_src_e_d    = alu_src_e_q;
        mem_to_reg_e_d = mem_to_reg_e_q;
        mem_write_e_d  = mem_write_e_q;
        pc_src_e_d     = pc_src_e_q;
        alu_ctl_e_d    = alu_ctl_e_q;
        valid_e_d      = valid_e_q;
        result_w_d     = result_w_q;
        wa_w_d         = wa_w_q;
        reg_write_w_d  = reg_write_w_q;
        valid_w_d      = valid_w_q;
        flags_d        = flags_q;
        if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d           = branch_s ? alu_res_s[AW-1:0] : pc_inc_s;
            op_a_e_d       = rd1_s;
            op_b_e_d       = rd2_s;
            imm_e_d        = imm_s;
            ra1_e_d        = ra1_s;
            ra2_e_d        = ra2_s;
            wa_e_d         = wa_s;
            reg_write_e_d  = regWrite;
            alu_src_e_d    = aluSrc;
            mem_to_reg_e_d = memToReg;
            mem_write_e_d  = memWrite;
            pc_src_e_d     = PCSrc;
            alu_ctl_e_d    = aluControl;
            // The instruction fetched behind a taken branch becomes a bubble.
            valid_e_d      = ~branch_s;
            result_w_d     = result_e_s;
            wa_w_d         = wa_e_q;
            reg_write_w_d  = reg_write_e_q;
            valid_w_d      = valid_e_q;
            flags_d        = valid_e_q ? {(alu_res_s == '0), alu_res_s[DW-1], alu_c_s, alu_v_s} : flags_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q           <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            op_a_e_q       <= '0;
            op_b_e_q       <= '0;
            imm_e_q        <= '0;
            ra1_e_q        <= '0;
            ra2_e_q        <= '0;
            wa_e_q         <= '0;
            reg_write_e_q  <= 1'b0;
            alu_src_e_q    <= 1'b0;
            mem_to_reg_e_q <= 1'b0;
            mem_write_e_q  <= 1'b0;
            pc_src_e_q     <= 1'b0;
            alu_ctl_e_q    <= 2'b00;
            valid_e_q      <= 1'b0;
            result_w_q     <= '0;
            wa_w_q         <= '0;
            reg_write_w_q  <= 1'b0;
            valid_w_q      <= 1'b0;
            flags_q        <= 4'b0000;
        end else begin
            pc_q           <= pc_d;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
            op_a_e_q       <= op_a_e_d;
            op_b_e_q       <= op_b_e_d;
            imm_e_q        <= imm_e_d;
            ra1_e_q        <= ra1_e_d;
            ra2_e_q        <= ra2_e_d;
            wa_e_q         <= wa_e_d;
            reg_write_e_q  <= reg_write_e_d;
            alu_src_e_q    <= alu_src_e_d;
            mem_to_reg_e_q <= mem_to_reg_e_d;
            mem_write_e_q  <= mem_write_e_d;
            pc_src_e_q     <= pc_src_e_d;
            alu_ctl_e_q    <= alu_ctl_e_d;
            valid_e_q      <= valid_e_d;
            result_w_q     <= result_w_d;
            wa_w_q         <= wa_w_d;
            reg_write_w_q  <= reg_write_w_d;
            valid_w_q      <= valid_w_d;
            flags_q        <= flags_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.memAddr    = alu_res_s[AW-1:0];
    assign bus.memWData   = fwd_b_s;
    assign bus.memWE      = mem_write_e_q & valid_e_q & ~stall;
    assign cero           = flags_q[3];
    assign negativo       = flags_q[2];
    assign acarreo        = flags_q[1];
    assign desbordamiento = flags_q[0];
endmodule

// File: tb/tb_pipe_datapath_p.sv
// Self-checking bench for pipe_datapath_p: table of instructions with a
// scoreboard of E-stage expectations, plus reset, stall and pc-wrap sequences.
module tb_pipe_datapath_p;
    typedef struct packed {
        logic        valid;
        logic [15:0] addr;
        logic        we;
        logic [23:0] wdata;
        logic [3:0]  flags;
    } exp_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [23:0] inst;
        logic [6:0]  ctrl;
        logic [1:0]  aluc;
        logic        stall;
        exp_t        e;
    } vec_t;

    localparam logic [6:0] C_RW = 7'b1000000;
    localparam logic [6:0] C_AS = 7'b0100000;
    localparam logic [6:0] C_IS = 7'b0010000;
    localparam logic [6:0] C_MR = 7'b0001000;
    localparam logic [6:0] C_MW = 7'b0000100;
    localparam logic [6:0] C_R2 = 7'b0000010;
    localparam logic [6:0] C_PS = 7'b0000001;

    logic clk, rst, rst2, stall;
    logic regWrite, aluSrc, immSrc, memToReg, memWrite, ra2Src, PCSrc;
    logic [1:0] aluControl;
    logic cero, negativo, acarreo, desbordamiento;
    logic cero2, negativo2, acarreo2, desbordamiento2;
    logic zero_s;
    logic [23:0] tb_mem [256];

    int checks = 0;
    int errors = 0;
    exp_t sbq[$];
    logic [3:0] flag_exp;
    vec_t tbl [24];
    vec_t post [4];

    pipe_datapath_p_if #(.DW(24), .AW(16)) bus ();
    pipe_datapath_p_if #(.DW(24), .AW(4))  bus2 ();

    pipe_datapath_p #(.DW(24), .AW(16), .NREG(16)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .regWrite(regWrite), .aluSrc(aluSrc), .immSrc(immSrc), .memToReg(memToReg),
        .memWrite(memWrite), .ra2Src(ra2Src), .PCSrc(PCSrc), .aluControl(aluControl),
        .bus(bus),
        .cero(cero), .negativo(negativo), .acarreo(acarreo), .desbordamiento(desbordamiento)
    );

    pipe_datapath_p #(.DW(24), .AW(4), .NREG(16)) dut_wrap (
        .clk(clk), .rst(rst2), .stall(zero_s),
        .regWrite(zero_s), .aluSrc(zero_s), .immSrc(zero_s), .memToReg(zero_s),
        .memWrite(zero_s), .ra2Src(zero_s), .PCSrc(zero_s), .aluControl({zero_s, zero_s}),
        .bus(bus2),
        .cero(cero2), .negativo(negativo2), .acarreo(acarreo2), .desbordamiento(desbordamiento2)
    );

    assign zero_s        = 1'b0;
    assign bus2.inst     = 24'h000000;
    assign bus2.memRData = 24'h000000;
    assign bus.memRData  = (bus.memAddr == 16'h0040) ? 24'h7FFFFF : tb_mem[bus.memAddr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple data memory: cleared in reset, written on memWE.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= 24'h000000;
        end else if (bus.memWE) begin
            tb_mem[bus.memAddr[7:0]] <= bus.memWData;
        end
    end

    function automatic logic [23:0] mk(input logic [3:0] rd, input logic [3:0] rn, input logic [11:0] imm);
        return {4'h0, rd, rn, imm};
    endfunction

    function automatic exp_t ex(input logic v, input logic [15:0] a, input logic w,
                                input logic [23:0] d, input logic [3:0] f);
        ex.valid = v; ex.addr = a; ex.we = w; ex.wdata = d; ex.flags = f;
    endfunction

    function automatic vec_t mv(input logic [15:0] pc, input logic [23:0] inst, input logic [6:0] ctrl,
                                input logic [1:0] aluc, input logic st, input exp_t e);
        mv.pc = pc; mv.inst = inst; mv.ctrl = ctrl; mv.aluc = aluc; mv.stall = st; mv.e = e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] flags_now();
        return {28'h0, cero, negativo, acarreo, desbordamiento};
    endfunction

    // Drive one D-stage instruction, check pc, flags and the E-stage item.
    task automatic apply(input vec_t v);
        exp_t cur;
        bus.inst = v.inst;
        {regWrite, aluSrc, immSrc, memToReg, memWrite, ra2Src, PCSrc} = v.ctrl;
        aluControl = v.aluc;
        stall = v.stall;
        if (!v.stall) sbq.push_back(v.e);
        @(negedge clk);
        chk("pc", {16'h0, bus.pc}, {16'h0, v.pc});
        chk("flags", flags_now(), {28'h0, flag_exp});
        if (v.stall) begin
            chk("memWE_stall", {31'h0, bus.memWE}, 32'h0);
        end else if (sbq.size() > 1) begin
            cur = sbq.pop_front();
            chk("memWE", {31'h0, bus.memWE}, {31'h0, cur.valid & cur.we});
            if (cur.valid) begin
                chk("memAddr", {16'h0, bus.memAddr}, {16'h0, cur.addr});
                if (cur.we) chk("memWData", {8'h0, bus.memWData}, {8'h0, cur.wdata});
                flag_exp = cur.flags;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; rst2 = 1'b0; stall = 1'b0;
        {regWrite, aluSrc, immSrc, memToReg, memWrite, ra2Src, PCSrc} = 7'b0;
        aluControl = 2'b00;
        bus.inst = 24'h000000;
        flag_exp = 4'b0000;

        tbl[0]  = mv(16'h0000, mk(4'd1, 4'd0, 12'h005), C_RW | C_AS, 2'b00, 1'b0, ex(1'b1, 16'h0005, 1'b0, 24'h0, 4'b0000));
        tbl[1]  = mv(16'h0001, mk(4'd2, 4'd1, 12'h100), C_RW,        2'b00, 1'b0, ex(1'b1, 16'h000A, 1'b0, 24'h0, 4'b0000));
        tbl[2]  = mv(16'h0002, mk(4'd3, 4'd2, 12'h200), C_RW,        2'b01, 1'b0, ex(1'b1, 16'h0000, 1'b0, 24'h0, 4'b1010));
        tbl[3]  = mv(16'h0003, mk(4'd0, 4'd0, 12'h020), C_AS | C_PS, 2'b00, 1'b0, ex(1'b1, 16'h0020, 1'b0, 24'h0, 4'b0000));
        tbl[4]  = mv(16'h0004, mk(4'd2, 4'd0, 12'h010), C_RW | C_AS | C_MW | C_R2, 2'b00, 1'b1, ex(1'b0, 16'h0, 1'b0, 24'h0, 4'b0));
        tbl[5]  = mv(16'h0004, mk(4'd2, 4'd0, 12'h010), C_RW | C_AS | C_MW | C_R2, 2'b00, 1'b0, ex(1'b0, 16'h0, 1'b0, 24'h0, 4'b0));
        tbl[6]  = mv(16'h0020, mk(4'd2, 4'd0, 12'h010), C_AS | C_MW | C_R2, 2'b00, 1'b0, ex(1'b1, 16'h0010, 1'b1, 24'h00000A, 4'b0000));
        for (int i = 7; i < 10; i++)
            tbl[i] = mv(16'h0021, mk(4'd4, 4'd0, 12'h010), C_RW | C_AS | C_MR, 2'b00, 1'b1, ex(1'b0, 16'h0, 1'b0, 24'h0, 4'b0));
        tbl[10] = mv(16'h0021, mk(4'd4, 4'd0, 12'h010), C_RW | C_AS | C_MR, 2'b00, 1'b0, ex(1'b1, 16'h0010, 1'b0, 24'h0, 4'b0000));
        tbl[11] = mv(16'h0022, mk(4'd5, 4'd4, 12'h001), C_RW | C_AS, 2'b00, 1'b0, ex(1'b1, 16'h000B, 1'b0, 24'h0, 4'b0000));
        tbl[12] = mv(16'h0023, mk(4'd6, 4'd0, 12'hFFF), C_RW | C_AS | C_IS, 2'b00, 1'b0, ex(1'b1, 16'hFFFF, 1'b0, 24'h0, 4'b0100));
        tbl[13] = mv(16'h0024, mk(4'd7, 4'd6, 12'h001), C_RW | C_AS, 2'b00, 1'b0, ex(1'b1, 16'h0000, 1'b0, 24'h0, 4'b1010));
        tbl[14] = mv(16'h0025, mk(4'd8, 4'd0, 12'h040), C_RW | C_AS | C_MR, 2'b00, 1'b0, ex(1'b1, 16'h0040, 1'b0, 24'h0, 4'b0000));
        tbl[15] = mv(16'h0026, mk(4'd9, 4'd8, 12'h001), C_RW | C_AS, 2'b00, 1'b0, ex(1'b1, 16'h0000, 1'b0, 24'h0, 4'b0101));
        tbl[16] = mv(16'h0027, mk(4'd10, 4'd0, 12'h00F), C_RW | C_AS, 2'b00, 1'b0, ex(1'b1, 16'h000F, 1'b0, 24'h0, 4'b0000));
        tbl[17] = mv(16'h0028, mk(4'd11, 4'd0, 12'h0F0), C_RW | C_AS, 2'b00, 1'b0, ex(1'b1, 16'h00F0, 1'b0, 24'h0, 4'b0000));
        tbl[18] = mv(16'h0029, mk(4'd12, 4'd10, 12'hB00), C_RW, 2'b10, 1'b0, ex(1'b1, 16'h0000, 1'b0, 24'h0, 4'b1000));
        tbl[19] = mv(16'h002A, mk(4'd13, 4'd10, 12'hB00), C_RW, 2'b11, 1'b0, ex(1'b1, 16'h00FF, 1'b0, 24'h0, 4'b0000));
        tbl[20] = mv(16'h002B, mk(4'd13, 4'd15, 12'h000), C_RW | C_AS, 2'b00, 1'b0, ex(1'b1, 16'h002C, 1'b0, 24'h0, 4'b0000));
        tbl[21] = mv(16'h002C, mk(4'd0, 4'd13, 12'h000), C_AS, 2'b00, 1'b0, ex(1'b1, 16'h002C, 1'b0, 24'h0, 4'b0000));
        tbl[22] = mv(16'h002D, mk(4'd0, 4'd0, 12'h000), C_AS, 2'b00, 1'b0, ex(1'b1, 16'h0000, 1'b0, 24'h0, 4'b1000));
        tbl[23] = mv(16'h002E, mk(4'd0, 4'd0, 12'h000), C_AS, 2'b00, 1'b0, ex(1'b1, 16'h0000, 1'b0, 24'h0, 4'b1000));

        post[0] = mv(16'h0000, mk(4'd1, 4'd0, 12'h060), C_AS | C_MW | C_R2, 2'b00, 1'b0, ex(1'b1, 16'h0060, 1'b1, 24'h000000, 4'b0000));
        for (int i = 1; i < 4; i++)
            post[i] = mv(16'(i), mk(4'd0, 4'd0, 12'h000), C_AS, 2'b00, 1'b0, ex(1'b1, 16'h0000, 1'b0, 24'h0, 4'b1000));

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        chk("reset_pc", {16'h0, bus.pc}, 32'h0);
        chk("reset_memWE", {31'h0, bus.memWE}, 32'h0);
        chk("reset_flags", flags_now(), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 24; i++) apply(tbl[i]);

        // Branch to 0x40 carrying a register write, then reset while it sits in E.
        apply(mv(16'h002F, mk(4'd1, 4'd0, 12'h040), C_RW | C_AS | C_PS, 2'b00, 1'b0,
                 ex(1'b1, 16'h0040, 1'b0, 24'h0, 4'b0000)));
        rst = 1'b0;
        #1;
        chk("async_reset_pc", {16'h0, bus.pc}, 32'h0);
        chk("async_reset_memWE", {31'h0, bus.memWE}, 32'h0);
        chk("async_reset_flags", flags_now(), 32'h0);
        sbq.delete();
        flag_exp = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) apply(post[i]);

        // pc wrap on the AW=4 instance.
        rst2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("wrap_pc", {28'h0, bus2.pc}, 32'(i % 16));
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_datapath_p.md
# pipe_datapath_p

Parametrised three-stage pipelined datapath, the successor to the single-issue ALU datapath. It takes the 24-bit instruction and the decoded control bits from the external control unit, and owns the PC, an internal register file, sign extension, the ALU and flag register. It drives the instruction and data memory interfaces. Unlike the previous generation, it adds full result forwarding, register-file write-through, branch flush with a one-cycle bubble, a global stall, and generic data width and register count.

## Interface
- DW, 24: data/ALU width (≥ 12)
- AW, 16: PC and data address width (≤ DW)
- NREG, 16: register count; index width RW = $clog2(NREG), RW ≤ 4 (instruction fields are 4 bits)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- stall  in  1  1 = freeze PC, pipeline registers, register file and flags
- inst  in  24  instruction at `pc`; fields Rd=[19:16], Rn=[15:12], Rm=[11:8], imm12=[11:0]
- regWrite, aluSrc, immSrc, memToReg, memWrite, ra2Src, PCSrc  in  1 each  decoded controls for `inst`
- aluControl  in  2  00 add, 01 sub, 10 and, 11 or
- pc  out  AW  fetch address
- memAddr  out  AW  ALU result [AW-1:0] of E stage
- memWData  out  DW  forwarded second register operand of E stage
- memWE  out  1  memWrite_E & validE & ~stall
- memRData  in  DW  asynchronous read data for memAddr
- cero, negativo, acarreo, desbordamiento  out  1 each  registered Z/N/C/V flags

## Operation
- Stages: D (combinational decode of `inst`), E (execute + memory), W (writeback).
- D: ra1=Rn; ra2 = ra2Src ? Rd : Rm; wa=Rd. The immediate is imm12 zero-extended (immSrc=0) or sign-extended (immSrc=1) to DW.
- Register file: NREG×DW. Written in W when regWrite_W & validW & ~stall. Reading index NREG-1 returns {0, pc+1}, and writes to it are ignored. A same-cycle W write to the register being read in D is bypassed (write-through).
- D→E register captures operands, immediate, wa and controls, and sets validE=1.
- E forwarding: each source equal to wa_W with regWrite_W & validW & wa_W≠NREG-1 takes result_W; otherwise the latched operand is used.
- srcB = aluSrc_E ? imm_E : fwdB. ALU operates on DW bits.
- add/sub: C = carry out (for sub, C = no borrow, i.e. A≥B unsigned), V = signed overflow. and/or: C=V=0. Z and N come from the result for all ops.
- Flags are registered at the end of E when validE & ~stall.
- result_E = memToReg_E ? memRData : aluResult. It is registered into W along with wa and regWrite, and validW ← validE.
- Branch: when PCSrc_E & validE & ~stall, pc ← aluResult[AW-1:0] and the D instruction is squashed. In that cycle the E register is loaded as a bubble (validE=0), so the squashed instruction neither writes nor stores. Otherwise pc ← pc+1, wrapping at 2^AW−1 → 0.
- Stall: every register holds its value; memWE is forced to 0; outputs stay stable.

## Timing
- Reset (rst=0, asynchronous): pc=0, validE=validW=0, all registers=0, flags=0, memWE=0. The first fetch is at pc=0 after rst rises.
- Throughput: one instruction per cycle with no stall and no branch.
- Latency: issue in D at cycle t; ALU result and flags at t+1; register write at the t+2 edge.
- Dependent back-to-back instructions need no bubble, via W→E forwarding and write-through.
- Taken branch costs exactly one bubble.
- A branch asserted while stall=1 takes effect on the first cycle with stall=0.
- Reset mid-operation discards in-flight E/W contents with no write.

## Test plan
- Reset: rst=0 for 3 cycles → pc=0, memWE=0, flags 0. Release → pc sequence 0,1,2,3; at AW=4, pc 15→0.
- Forwarding: R1=R0+imm5, then R2=R1+R1 (ra2Src=0, aluSrc=0) → R2=10; R3=R2−R2 → cero=1, acarreo=1.
- Flags: 0x7FFFFF+1 → desbordamiento=1, negativo=1. 0xFFFFFF+1 → acarreo=1, cero=1. 0x0F and 0xF0 → cero=1, C=V=0.
- Branch: PCSrc instruction at pc=3 with target 0x20 → pc 3,4,0x20,0x21. The store at pc=4 produces no memWE, and no register write.
- Memory and stall: store R2(=10) to 0x10 → memWE=1 for exactly one cycle with memWData=10, memAddr=0x10. Load from 0x10 (memRData=10) into R4, then R5=R4+1 → 11. Stall held 3 cycles → pc frozen, memWE=0.
- Async reset during branch: drop rst while the branch is in E → pc=0 immediately; the target register is unchanged.
